postfix_evaluator: RTL

POSTFIX_EVALUATOR -- requirements
Module: postfix_evaluator

---
 rtl/postfix_evaluator_pkg.sv | 27 ++
 rtl/pow_unit.sv | 68 ++++++
 rtl/postfix_evaluator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/postfix_evaluator_pkg.sv
// Shared calculator definitions: opcode encoding, evaluator FSM states and default sizes.
// Also imported by the infix-to-postfix converter.
package postfix_evaluator_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 20;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_EXP = 3'b100;
    localparam logic [2:0] OP_EQ  = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StAck,
        StExec,
        StExp,
        StResult
    } state_e;

    function automatic logic is_binary_op(input logic [2:0] op);
        return op <= OP_EXP;
    endfunction

endpackage

// File: rtl/pow_unit.sv
// Signed-exponent power by right-to-left square-and-multiply, one exponent bit per cycle.
// Negative exponents give 0; a zero exponent gives 1. All arithmetic wraps at WIDTH bits.
module pow_unit
    import postfix_evaluator_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_i,
    input  logic [WIDTH-1:0] base_i,
    input  logic [WIDTH-1:0] exp_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] exp_q, exp_d;

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        res_d  = res_q;
        base_d = base_q;
        exp_d  = exp_q;
        if (start_i) begin
            busy_d = 1'b1;
            base_d = base_i;
            // A negative exponent collapses to an immediate zero result.
            res_d  = exp_i[WIDTH-1] ? '0 : WIDTH'(1);
            exp_d  = exp_i[WIDTH-1] ? '0 : exp_i;
        end else if (busy_q) begin
            if (exp_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                if (exp_q[0]) begin
                    res_d = res_q * base_q;
                end
                base_d = base_q * base_q;
                exp_d  = exp_q >> 1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
            base_q <= '0;
            exp_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            res_q  <= res_d;
            base_q <= base_d;
            exp_q  <= exp_d;
        end
    end

    assign done_o   = done_q;
    assign result_o = res_q;

endmodule

// File: rtl/postfix_evaluator.sv
// Postfix (RPN) expression evaluator over a token stream with an inline operand stack.
// Errors are sticky until '=' reports them; '=' waits for the consumer before acking.
module postfix_evaluator
    import postfix_evaluator_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             input_stb,
    input  logic [WIDTH-1:0] input_data,
    input  logic             is_input_operator,
    output logic             input_ack,
    output logic             result_stb,
    output logic [WIDTH-1:0] result_data,
    output logic             result_error,
    input  logic             result_ack
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic [2:0]       op_q, op_d;
    logic             ack_q, ack_d;
    logic             res_stb_q, res_stb_d;
    logic             res_err_q, res_err_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;

    logic [AW-1:0]    top_idx, nos_idx;
    logic [WIDTH-1:0] opa, opb, alu_res, div_b;
    logic             div_zero, div_ovf;
    logic             pow_start, pow_done;
    logic [WIDTH-1:0] pow_result;

    assign top_idx = AW'(count_q - CW'(1));
    assign nos_idx = AW'(count_q - CW'(2));
    assign opa     = stack_q[nos_idx];
    assign opb     = stack_q[top_idx];

    // Divisor is steered to 1 for /0 and MIN/-1 so the divider never sees an undefined case.
    assign div_zero = (opb == '0);
    assign div_ovf  = (opa == MIN_VAL) && (opb == '1);
    assign div_b    = (div_zero || div_ovf) ? WIDTH'(1) : opb;

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_MUL:  alu_res = opa * opb;
            OP_DIV:  begin
                if (div_ovf) begin
                    alu_res = MIN_VAL;
                end else if (!div_zero) begin
                    alu_res = WIDTH'($signed(opa) / $signed(div_b));
                end
            end
            default: alu_res = '0;
        endcase
    end

    pow_unit #(
        .WIDTH (WIDTH)
    ) u_pow (
        .CLK      (CLK),
        .RST      (RST),
        .start_i  (pow_start),
        .base_i   (opa),
        .exp_i    (opb),
        .done_o   (pow_done),
        .result_o (pow_result)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        err_d      = err_q;
        op_d       = op_q;
        ack_d      = 1'b0;
        res_stb_d  = res_stb_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        wr_en      = 1'b0;
        wr_idx     = top_idx;
        wr_data    = input_data;
        pow_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (input_stb) begin
                    if (is_input_operator && input_data[2:0] == OP_EQ) begin
                        state_d   = StResult;
                        res_stb_d = 1'b1;
                        if (!err_q && count_q == CW'(1)) begin
                            res_data_d = stack_q[0];
                            res_err_d  = 1'b0;
                        end else begin
                            res_data_d = '0;
                            res_err_d  = 1'b1;
                        end
                    end else begin
                        ack_d   = 1'b1;
                        state_d = StAck;
                        if (!err_q) begin
                            if (!is_input_operator) begin
                                if (count_q == FULL) begin
                                    err_d = 1'b1;
                                end else begin
                                    wr_en   = 1'b1;
                                    wr_idx  = AW'(count_q);
                                    count_d = count_q + CW'(1);
                                end
                            end else if (!is_binary_op(input_data[2:0]) ||
                                         count_q < CW'(2)) begin
                                err_d = 1'b1;
                            end else begin
                                ack_d   = 1'b0;
                                op_d    = input_data[2:0];
                                state_d = StExec;
                            end
                        end
                    end
                end
            end
            StExec: begin
                if (op_q == OP_EXP) begin
                    pow_start = 1'b1;
                    state_d   = StExp;
                end else begin
                    wr_en   = 1'b1;
                    wr_idx  = nos_idx;
                    wr_data = alu_res;
                    count_d = count_q - CW'(1);
                    ack_d   = 1'b1;
                    state_d = StAck;
                    if (op_q == OP_DIV && div_zero) begin
                        err_d = 1'b1;
                    end
                end
            end
            StExp: begin
                if (pow_done) begin
                    wr_en   = 1'b1;
                    wr_idx  = nos_idx;
                    wr_data = pow_result;
                    count_d = count_q - CW'(1);
                    ack_d   = 1'b1;
                    state_d = StAck;
                end
            end
            StResult: begin
                if (result_ack) begin
                    res_stb_d  = 1'b0;
                    res_data_d = '0;
                    res_err_d  = 1'b0;
                    count_d    = '0;
                    err_d      = 1'b0;
                    ack_d      = 1'b1;
                    state_d    = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            count_q    <= '0;
            err_q      <= 1'b0;
            op_q       <= OP_ADD;
            ack_q      <= 1'b0;
            res_stb_q  <= 1'b0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            err_q      <= err_d;
            op_q       <= op_d;
            ack_q      <= ack_d;
            res_stb_q  <= res_stb_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    // Stack contents need no reset; the count alone defines which entries are live.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            stack_q[wr_idx] <= wr_data;
        end
    end

    assign input_ack    = ack_q;
    assign result_stb   = res_stb_q;
    assign result_data  = res_data_q;
    assign result_error = res_err_q;

endmodule
